// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the fetch stage, the decoder and the control stage:
// datapath widths, the default reset PC, the control-transfer opcodes and the
// {pc, inst} entry carried through the prefetch buffer.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int XLEN    = 16;
  localparam int INST_W  = 16;
  localparam int ENTRY_W = XLEN + INST_W;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 16'h0000;

  // Control-transfer opcodes (instruction bits [15:12]); the fetch stage only
  // sees their targets through the redirect port.
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1101;
  localparam logic [3:0] OP_CALL = 4'b1110;
  localparam logic [3:0] OP_RET  = 4'b1111;

  // One prefetch buffer entry: the fetched word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential PC advance; wraps 16'hFFFF -> 16'h0000 naturally.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 16'h0001;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, inst} entries between instruction memory and
// the decoder. A flush empties it in one cycle and overrides push/pop.
//
// Ports
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_flush       discard every entry (pointers and count return to zero)
//   i_push        write i_wdata at the tail (ignored when no slot is free)
//   i_wdata       entry to write
//   i_pop         drop the head entry (ignored when empty)
//   o_rdata       head entry (storage read directly, no combinational bypass)
//   o_count       number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop_ok;
  logic          w_push_ok;

  // Qualify push/pop against occupancy; a push into a full FIFO is allowed
  // only when the head leaves in the same cycle.
  always_comb begin
    w_pop_ok  = i_pop & (r_count != {CW{1'b0}});
    w_push_ok = i_push & ((r_count != DEPTH_C) | w_pop_ok);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      r_count <= r_count + {{(CW-1){1'b0}}, w_push_ok} - {{(CW-1){1'b0}}, w_pop_ok};
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. Owns the program counter, issues one word read at
// a time to instruction memory (req/gnt then in-order rvalid), buffers the
// returned words with their addresses and hands them to decode over a
// valid/ready handshake. A redirect reloads the PC, flushes the buffer and
// marks any in-flight response for discard.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_fetch_en         0 stops new requests (in-flight response still taken)
//   i_redirect_valid   one-cycle pulse: load PC from i_redirect_pc
//   i_redirect_pc      new fetch address (word address)
//   o_imem_req         read request to instruction memory
//   o_imem_addr        request address (the current PC)
//   i_imem_gnt         request accepted this cycle
//   i_imem_rvalid      read data valid (in order, >= 1 cycle after grant)
//   i_imem_rdata       instruction word
//   o_inst_valid       buffer head valid
//   i_inst_ready       decode takes the head this cycle
//   o_inst, o_inst_pc  head instruction and its address
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_en,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [XLEN-1:0]   o_inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Fetch control state.
  logic [XLEN-1:0] r_pc;           // next address to request
  logic [XLEN-1:0] r_tag;          // address of the request in flight
  logic            r_outstanding;  // one request granted, response pending
  logic            r_discard;      // pending response belongs to a stale path

  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic            w_inst_valid;
  logic            w_req;
  logic            w_grant;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_next;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // Request/credit logic. A response is only meaningful while a request is
  // outstanding, so a stray rvalid (e.g. one that straddled a reset) is
  // ignored. The occupancy after this cycle's push/pop must leave a free slot
  // for the response of any request issued now.
  always_comb begin
    w_inst_valid = (w_count != {CW{1'b0}});
    w_rsp        = i_imem_rvalid & r_outstanding;
    w_push       = w_rsp & ~r_discard & ~i_redirect_valid;
    w_pop        = w_inst_valid & i_inst_ready & ~i_redirect_valid;
    w_count_next = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    w_req        = ~i_rst & i_fetch_en & ~i_redirect_valid
                 & (~r_outstanding | w_rsp)
                 & (w_count_next < DEPTH_C);
    w_grant      = w_req & i_imem_gnt;
    w_push_entry = '{pc: r_tag, inst: i_imem_rdata};
  end

  // PC, in-flight tag, outstanding and discard tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_tag         <= {XLEN{1'b0}};
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      if (i_redirect_valid) begin
        r_pc <= i_redirect_pc;
      end else if (w_grant) begin
        r_pc <= pc_inc(r_pc);
      end

      if (w_grant) begin
        r_tag <= r_pc;
      end

      // A grant in the same cycle as a response keeps the pipe full.
      if (w_grant) begin
        r_outstanding <= 1'b1;
      end else if (w_rsp) begin
        r_outstanding <= 1'b0;
      end

      // The response already on the bus in a redirect cycle is dropped via
      // w_push; only a response still to come needs the discard flag. Later
      // redirects leave the flag set until that single response arrives.
      if (i_redirect_valid && r_outstanding && !w_rsp) begin
        r_discard <= 1'b1;
      end else if (w_rsp) begin
        r_discard <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = w_inst_valid;
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed phases push hand-computed
// {pc, inst} entries; monitors pop and compare on every decode handshake.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_en, redirect_valid, imem_gnt, imem_rvalid, inst_ready;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [15:0] imem_addr, inst, inst_pc;

  // Second instance with a wrapping reset PC.
  logic        fetch_en2, inst_ready2, imem_rvalid2, gnt2, redir2;
  logic [15:0] imem_rdata2, redir_pc2;
  logic        imem_req2, inst_valid2;
  logic [15:0] imem_addr2, inst2, inst_pc2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;
  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];

  inst_fetch #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_en(fetch_en),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst(inst), .o_inst_pc(inst_pc)
  );

  inst_fetch #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_fetch_en(fetch_en2),
    .i_redirect_valid(redir2), .i_redirect_pc(redir_pc2),
    .o_imem_req(imem_req2), .o_imem_addr(imem_addr2), .i_imem_gnt(gnt2),
    .i_imem_rvalid(imem_rvalid2), .i_imem_rdata(imem_rdata2),
    .o_inst_valid(inst_valid2), .i_inst_ready(inst_ready2),
    .o_inst(inst2), .o_inst_pc(inst_pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    fetch_en = 1'b0; fetch_en2 = 1'b0;
    inst_ready = 1'b0; inst_ready2 = 1'b0;
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    pend_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Memory model (main DUT): record grants, answer after 'lat' cycles.
  initial begin
    pend_t p;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        p.due  = cyc + lat;
        p.addr = imem_addr;
        pend_q.push_back(p);
      end
    end
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Memory model (second DUT): always granted, 1-cycle latency.
  initial begin
    logic        g2;
    logic [15:0] a2;
    imem_rvalid2 = 1'b0;
    imem_rdata2  = 16'h0000;
    forever begin
      @(negedge clk);
      g2 = imem_req2;
      a2 = imem_addr2;
      @(posedge clk);
      #1;
      imem_rvalid2 = g2;
      imem_rdata2  = mem_word(a2);
    end
  end

  // Scoreboard monitors: compare on each handshake that will take effect.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_unexpected: got %h expected nothing", {inst_pc, inst});
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst", {inst_pc, inst}, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid2 && inst_ready2) begin
        if (exp2_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb2_unexpected: got %h expected nothing", {inst_pc2, inst2});
        end else begin
          e = exp2_q.pop_front();
          chk("sb2_inst", {inst_pc2, inst2}, e);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_gnt = 1'b0; inst_ready = 1'b0;
    fetch_en2 = 1'b0; inst_ready2 = 1'b0; gnt2 = 1'b1;
    redir2 = 1'b0; redir_pc2 = 16'h0000;

    // Reset values.
    tick(); tick();
    @(negedge clk);
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_addr",  {16'd0, imem_addr},  32'h0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  {16'd0, inst},       32'h0000);
    chk("rst_pc",    {16'd0, inst_pc},    32'h0000);
    chk("rst_addr2", {16'd0, imem_addr2}, 32'h0000FFFE);

    // Streaming: 1-cycle memory, ready=1.
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) exp_q.push_back({16'(i), 16'hA000 + 16'(i)});
    tick(); fetch_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;   // c0
    tick(); @(negedge clk); chk("lat_c1_valid", {31'd0, inst_valid}, 32'd0);
    for (int c = 2; c <= 7; c++) begin
      tick(); @(negedge clk); chk("stream_valid", {31'd0, inst_valid}, 32'd1);
    end

    // Back-pressure: ready=0 for 10 cycles.
    for (int i = 6; i < 12; i++) exp_q.push_back({16'(i), 16'hA000 + 16'(i)});
    tick(); inst_ready = 1'b0;                                      // c8
    for (int c = 9; c <= 17; c++) begin
      tick(); @(negedge clk);
      chk("full_req", {31'd0, imem_req}, 32'd0);
      chk("full_valid", {31'd0, inst_valid}, 32'd1);
    end
    chk("full_head_pc", {16'd0, inst_pc}, 32'h0006);
    for (int c = 18; c <= 23; c++) begin
      tick(); inst_ready = 1'b1;
    end
    tick(); inst_ready = 1'b0; fetch_en = 1'b0;                     // c24
    chk("drain_sb_empty", exp_q.size(), 32'd0);

    // Redirect to 0x0040 with a request in flight (3-cycle memory).
    do_reset();
    lat = 3;
    exp_q.push_back({16'h0040, 16'hA040});
    exp_q.push_back({16'h0041, 16'hA041});
    tick(); fetch_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;   // c0
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0040;          // c1
    @(negedge clk); chk("rd1_req_c1", {31'd0, imem_req}, 32'd0);
    tick(); redirect_valid = 1'b0;                                  // c2
    @(negedge clk);
    chk("rd1_req_c2",  {31'd0, imem_req}, 32'd0);
    chk("rd1_addr_c2", {16'd0, imem_addr}, 32'h0040);
    tick(); @(negedge clk);                                         // c3
    chk("rd1_req_c3",  {31'd0, imem_req}, 32'd1);
    chk("rd1_addr_c3", {16'd0, imem_addr}, 32'h0040);
    for (int c = 4; c <= 10; c++) begin
      tick(); @(negedge clk);
      chk("rd1_valid", {31'd0, inst_valid}, (c == 7 || c == 10) ? 32'd1 : 32'd0);
    end
    tick(); inst_ready = 1'b0; fetch_en = 1'b0;
    chk("rd1_sb_empty", exp_q.size(), 32'd0);

    // Redirect coinciding with rvalid and a pop.
    do_reset();
    lat = 1;
    exp_q.push_back({16'h0100, 16'hA100});
    exp_q.push_back({16'h0101, 16'hA101});
    tick(); fetch_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;   // c0
    tick(); @(negedge clk); chk("rd2_valid_c1", {31'd0, inst_valid}, 32'd0);
    tick(); redirect_valid = 1'b1; redirect_pc = 16'h0100;          // c2
    @(negedge clk);
    chk("rd2_req_c2",   {31'd0, imem_req},   32'd0);
    chk("rd2_valid_c2", {31'd0, inst_valid}, 32'd1);
    tick(); redirect_valid = 1'b0;                                  // c3
    @(negedge clk);
    chk("rd2_valid_c3", {31'd0, inst_valid}, 32'd0);
    chk("rd2_req_c3",   {31'd0, imem_req},   32'd1);
    chk("rd2_addr_c3",  {16'd0, imem_addr},  32'h0100);
    tick(); tick(); tick();                                         // c4..c6
    tick(); inst_ready = 1'b0; fetch_en = 1'b0;                     // c7
    chk("rd2_sb_empty", exp_q.size(), 32'd0);

    // Asynchronous reset mid-stream with a request outstanding.
    do_reset();
    lat = 1;
    for (int i = 0; i < 3; i++) exp_q.push_back({16'(i), 16'hA000 + 16'(i)});
    tick(); fetch_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;   // c0
    tick(); tick(); tick();                                         // c1..c3
    tick(); lat = 3;                                                // c4
    tick();                                                         // c5
    chk("mr_pre_addr",  {16'd0, imem_addr},  32'h0005);
    chk("mr_pre_pc",    {16'd0, inst_pc},    32'h0003);
    rst = 1'b1; imem_gnt = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
    #1;
    chk("mr_req",   {31'd0, imem_req},   32'd0);
    chk("mr_addr",  {16'd0, imem_addr},  32'h0000);
    chk("mr_valid", {31'd0, inst_valid}, 32'd0);
    chk("mr_inst",  {16'd0, inst},       32'h0000);
    chk("mr_pc",    {16'd0, inst_pc},    32'h0000);
    tick(); rst = 1'b0;                                             // c6
    tick(); @(negedge clk); chk("mr_stale_c7", {31'd0, inst_valid}, 32'd0);
    tick(); @(negedge clk);                                         // c8
    chk("mr_stale_c8", {31'd0, inst_valid}, 32'd0);
    chk("mr_req_c8",   {31'd0, imem_req},   32'd0);
    exp_q.push_back({16'h0000, 16'hA000});
    exp_q.push_back({16'h0001, 16'hA001});
    tick(); lat = 1; fetch_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;  // c9
    tick(); tick(); tick();                                         // c10..c12
    tick(); inst_ready = 1'b0; fetch_en = 1'b0;                     // c13
    chk("mr_sb_empty", exp_q.size(), 32'd0);

    // PC wrap from RESET_PC=16'hFFFE.
    do_reset();
    exp2_q.push_back({16'hFFFE, 16'h9FFE});
    exp2_q.push_back({16'hFFFF, 16'h9FFF});
    exp2_q.push_back({16'h0000, 16'hA000});
    exp2_q.push_back({16'h0001, 16'hA001});
    tick(); fetch_en2 = 1'b1; inst_ready2 = 1'b1;                   // c0
    for (int c = 1; c <= 5; c++) tick();
    tick(); inst_ready2 = 1'b0; fetch_en2 = 1'b0;                   // c6
    chk("wrap_sb_empty", exp2_q.size(), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the 16-bit program counter and issues word reads to instruction memory over a request/grant/response protocol. Returned instructions are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake. Execute/control logic can redirect the PC (BR, JMP, CALL, RET); a redirect flushes all stale fetch state.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
fetch_en  in  1  0 blocks new memory requests; an in-flight response is still accepted.
redirect_valid  in  1  one-cycle pulse; load the PC from redirect_pc.
redirect_pc  in  16  branch/jump/call/return target (word address).
imem_req  out  1  read request.
imem_addr  out  16  word address of the request.
imem_gnt  in  1  request accepted this cycle when imem_req=1.
imem_rvalid  in  1  read data valid; in order, at least 1 cycle after grant.
imem_rdata  in  16  instruction word.
inst_valid  out  1  FIFO head valid.
inst_ready  in  1  decode consumes the head this cycle.
inst  out  16  instruction to the decoder (FIFO head).
inst_pc  out  16  address of inst.

Behaviour:
- Reset (async, active-high): pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- State: pc (next address to request), outstanding (0/1; at most one request in flight), discard (drop the next response), FIFO of {pc,inst}, count 0..FIFO_DEPTH.
- Issue rule: imem_req=1 when fetch_en=1, redirect_valid=0, (outstanding=0 or imem_rvalid=1), and count_next + 1 <= FIFO_DEPTH. count_next is the count after this cycle's push/pop, so any issued request always has a FIFO slot reserved. imem_addr=pc, combinational from registers.
- Grant: when imem_req and imem_gnt are both 1, set outstanding=1, record the issued pc in the in-flight tag, and set pc=pc+1 (mod 2^16; 16'hFFFF wraps to 16'h0000).
- Response: when imem_rvalid=1 and discard=0, push {tag, imem_rdata} and clear outstanding, unless a new grant in the same cycle re-sets it. When discard=1, drop the data and clear discard and outstanding.
- Pop: inst_valid=(count!=0). When inst_valid and inst_ready are both 1, pop the head. Push and pop in the same cycle leave count unchanged.
- Latency: after a grant at cycle N and rvalid at N+1, inst_valid=1 at N+2. With a 1-cycle memory, gnt=1 and ready=1, throughput is 1 instruction/cycle in steady state, because issue overlaps rvalid.
- Redirect (highest priority):
  - In the redirect cycle: FIFO flushed (count=0, inst_valid=0 next cycle), pc=redirect_pc, imem_req=0.
  - A pop in the same cycle is ignored.
  - If outstanding=1 and no rvalid this cycle, set discard=1. A response arriving in the redirect cycle itself is dropped.
  - The first request to redirect_pc is issued the cycle after the redirect, once outstanding clears.
- Back-to-back redirects: the last one wins; discard stays set until the single in-flight response returns.
- FIFO full with inst_ready=0: no issue; pc holds; imem_req=0.
- fetch_en=0: no new requests; the FIFO still drains and fills from the in-flight response.
- imem_req/imem_addr may drop only on a redirect or a FIFO/credit change before grant; memory must not treat a dropped request as accepted.
- The module does not decode instructions; RET/CALL targets come from redirect_pc.

Decomposition:
- Shared package: XLEN=16, INST_W=16, RESET_PC default, opcode constants (BR=4'b1100, JMP=4'b1101, CALL=4'b1110, RET=4'b1111) shared with the decoder and the control stage.
- One sub-module: fetch_fifo (synchronous FIFO of {pc,inst}, width 32, depth FIFO_DEPTH, with flush, push, pop and count outputs). The fetch control and credit logic stay in inst_fetch.

Test Plan:
- Reset then gnt=1, 1-cycle rvalid, ready=1, memory[i]=16'hA000+i -> inst/inst_pc sequence 0xA000/0,0xA001/1,0xA002/2 with inst_valid continuous from cycle 2.
- ready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, imem_req=0 while full; releasing ready delivers them in order with no loss or duplication.
- Redirect to 16'h0040 while a request is in flight (3-cycle latency) -> stale response dropped, FIFO flushed, next delivered inst_pc=16'h0040.
- Redirect in the same cycle as imem_rvalid and inst_ready -> neither push nor pop takes effect; next imem_addr=redirect_pc.
- RESET_PC=16'hFFFE, free-run -> inst_pc 0xFFFE,0xFFFF,0x0000,0x0001.
- Assert rst mid-stream with outstanding=1 -> all outputs return to reset values immediately (async), and the late rvalid after reset is ignored (outstanding=0).
